// File: rtl/pwl_integ_dump_ctrl.sv
// Integrate-and-dump sequencer for a PWL integrator with reset: times dump, settle and
// integration windows, counts trigger edges per window. Optional HOLD timeout: INTEG_CTRL_TIMEOUT_EN.
module pwl_integ_dump_ctrl #(
    parameter int CW       = 8,
    parameter int WW       = 8,
    parameter int N_SETTLE = 1,
    parameter int T_OUT    = 64
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          cont,
    input  logic          abort,
    input  logic [CW-1:0] integ_len,
    input  logic [CW-1:0] dump_len,
    input  logic          trig_in,
    output logic          integ_rst,
    output logic          sample,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [WW-1:0] wrap_cnt,
    output logic          overrun
);

    typedef enum logic [2:0] {IDLE, DUMP, SETTLE, INTEG, HOLD} state_t;

    localparam logic [CW-1:0] SETTLE_LAST = (N_SETTLE > 0) ? CW'(N_SETTLE - 1) : '0;
    localparam logic [WW-1:0] WRAP_MAX    = '1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] integ_last;
    logic [CW-1:0] dump_last;
    logic          aborting;
    logic          trig_s1;
    logic          trig_s2;
    logic          trig_d;
    logic          trig_edge;
    logic          timeout;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_d  <= 1'b0;
        end else begin
            trig_s1 <= trig_in;
            trig_s2 <= trig_s1;
            trig_d  <= trig_s2;
        end
    end

    assign trig_edge = trig_s2 & ~trig_d;

`ifdef INTEG_CTRL_TIMEOUT_EN
    localparam int TW = (T_OUT > 1) ? $clog2(T_OUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(T_OUT - 1);

    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tcnt <= '0;
        end else if (state != HOLD) begin
            tcnt <= '0;
        end else if (!timeout) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign timeout = (state == HOLD) && (tcnt == T_LAST);
`else
    // Never fires: without the timeout build HOLD waits for the consumer forever.
    assign timeout = (T_OUT < 0);
`endif

    // Counters load "length-1" and count down, so outputs can be set one cycle ahead and stay registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            integ_last <= '0;
            dump_last  <= '0;
            aborting   <= 1'b0;
            integ_rst  <= 1'b1;
            sample     <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            wrap_cnt   <= '0;
            overrun    <= 1'b0;
        end else begin
            sample <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= DUMP;
                aborting  <= 1'b1;
                integ_rst <= 1'b1;
                busy      <= 1'b1;
                res_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state      <= DUMP;
                            aborting   <= 1'b0;
                            busy       <= 1'b1;
                            integ_rst  <= 1'b1;
                            overrun    <= 1'b0;
                            wrap_cnt   <= '0;
                            integ_last <= (integ_len == '0) ? '0 : integ_len - 1'b1;
                            dump_last  <= (dump_len == '0) ? '0 : dump_len - 1'b1;
                            cnt        <= (dump_len == '0) ? '0 : dump_len - 1'b1;
                        end
                    end
                    DUMP: begin
                        if (aborting) begin
                            state     <= IDLE;
                            aborting  <= 1'b0;
                            busy      <= 1'b0;
                            integ_rst <= 1'b1;
                        end else if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (N_SETTLE > 0) begin
                            state     <= SETTLE;
                            cnt       <= SETTLE_LAST;
                            integ_rst <= 1'b0;
                        end else begin
                            state     <= INTEG;
                            cnt       <= integ_last;
                            sample    <= (integ_last == '0);
                            integ_rst <= 1'b0;
                        end
                    end
                    SETTLE: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            state  <= INTEG;
                            cnt    <= integ_last;
                            sample <= (integ_last == '0);
                        end
                    end
                    INTEG: begin
                        if (trig_edge && wrap_cnt != WRAP_MAX) begin
                            wrap_cnt <= wrap_cnt + 1'b1;
                        end
                        if (cnt != '0) begin
                            cnt    <= cnt - 1'b1;
                            sample <= (cnt == CW'(1));
                        end else begin
                            state     <= HOLD;
                            integ_rst <= 1'b1;
                            res_valid <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (start) begin
                            overrun <= 1'b1;
                        end
                        if (res_ready || timeout) begin
                            res_valid <= 1'b0;
                            if (!res_ready) begin
                                overrun <= 1'b1;
                            end
                            if (cont) begin
                                state    <= DUMP;
                                cnt      <= dump_last;
                                wrap_cnt <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else if (cont) begin
                            // Continuous re-arm is being held off by an unconsumed result.
                            overrun <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        integ_rst <= 1'b1;
                        res_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwl_integ_dump_ctrl.sv
// Directed bench for pwl_integ_dump_ctrl: a default instance plus a WW=2, N_SETTLE=0, T_OUT=4
// instance sharing the same stimulus. Edge E0 is the edge that captures start.
module tb_pwl_integ_dump_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       abort = 1'b0;
    logic       trigIn = 1'b0;
    logic       resReady = 1'b0;
    logic [7:0] integLen = 8'd0;
    logic [7:0] dumpLen = 8'd0;

    logic       integRst, sample, busy, resValid, overrun;
    logic [7:0] wrapCnt;
    logic       integRst2, sample2, busy2, resValid2, overrun2;
    logic [1:0] wrapCnt2;

    int checkCount = 0;
    int errorCount = 0;
    int sampleAt, sampleAt2, sampleCount, sampleCount2;
    int runLen, lastRun;
    bit seenLow;
    logic [15:0] trigPat;

    pwl_integ_dump_ctrl dut (
        .clk(clk), .rstn(rstn), .start(start), .cont(cont), .abort(abort),
        .integ_len(integLen), .dump_len(dumpLen), .trig_in(trigIn),
        .integ_rst(integRst), .sample(sample), .busy(busy), .res_valid(resValid),
        .res_ready(resReady), .wrap_cnt(wrapCnt), .overrun(overrun)
    );

    pwl_integ_dump_ctrl #(.CW(8), .WW(2), .N_SETTLE(0), .T_OUT(4)) dut2 (
        .clk(clk), .rstn(rstn), .start(start), .cont(cont), .abort(abort),
        .integ_len(integLen), .dump_len(dumpLen), .trig_in(trigIn),
        .integ_rst(integRst2), .sample(sample2), .busy(busy2), .res_valid(resValid2),
        .res_ready(resReady), .wrap_cnt(wrapCnt2), .overrun(overrun2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] dl, input logic [7:0] il);
        dumpLen  = dl;
        integLen = il;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic clearTrack();
        sampleAt     = -1;
        sampleAt2    = -1;
        sampleCount  = 0;
        sampleCount2 = 0;
    endtask

    task automatic trackSamples(input int k);
        if (sample) begin
            sampleCount++;
            if (sampleAt < 0) sampleAt = k;
        end
        if (sample2) begin
            sampleCount2++;
            if (sampleAt2 < 0) sampleAt2 = k;
        end
    endtask

    initial begin
        tick();
        checkOutput("rst_integ_rst", integRst, 1);
        checkOutput("rst_sample", sample, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_res_valid", resValid, 0);
        checkOutput("rst_wrap_cnt", wrapCnt, 0);
        checkOutput("rst_overrun", overrun, 0);
        rstn = 1'b1;
        tick();

        // Basic window: dump 2, integ 5, trigger edges reach the detector after E3, E5, E7.
        applyStimulus(8'd2, 8'd5);
        checkOutput("start_busy", busy, 1);
        checkOutput("start_integ_rst", integRst, 1);
        clearTrack();
        trigPat = 16'b0000_0000_0101_0100;
        for (int k = 1; k <= 9; k++) begin
            trigIn = trigPat[k];
            tick();
            trackSamples(k);
        end
        trigIn = 1'b0;
        checkOutput("win_sample_at", sampleAt, 7);
        checkOutput("win_sample_once", sampleCount, 1);
        checkOutput("win_res_valid", resValid, 1);
        checkOutput("win_wrap_cnt", wrapCnt, 3);
        checkOutput("win_hold_integ_rst", integRst, 1);
        checkOutput("win2_sample_at", sampleAt2, 6);
        checkOutput("win2_wrap_cnt", wrapCnt2, 2);

        // Start while a result is pending.
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("ovr_overrun", overrun, 1);
        checkOutput("ovr_res_valid", resValid, 1);
        checkOutput("ovr_busy", busy, 1);
        checkOutput("ovr_wrap_stable", wrapCnt, 3);
        checkOutput("ovr2_overrun", overrun2, 1);
        resReady = 1'b1;
        tick();
        resReady = 1'b0;
        checkOutput("acc_busy", busy, 0);
        checkOutput("acc_res_valid", resValid, 0);
        checkOutput("acc_overrun_sticky", overrun, 1);

        // Abort captured on the third INTEG cycle (E6).
        applyStimulus(8'd2, 8'd5);
        checkOutput("abt_overrun_clear", overrun, 0);
        clearTrack();
        for (int k = 1; k <= 5; k++) begin
            tick();
            trackSamples(k);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        trackSamples(6);
        checkOutput("abt_dump_busy", busy, 1);
        checkOutput("abt_dump_integ_rst", integRst, 1);
        tick();
        trackSamples(7);
        checkOutput("abt_idle_busy", busy, 0);
        checkOutput("abt_idle_integ_rst", integRst, 1);
        checkOutput("abt_no_sample", sampleCount, 0);
        checkOutput("abt2_no_sample", sampleCount2, 0);
        checkOutput("abt2_idle_busy", busy2, 0);

        // Continuous mode, consumer always ready: 7-cycle period, gap of dump_len+1.
        cont = 1'b1;
        resReady = 1'b1;
        applyStimulus(8'd2, 8'd3);
        clearTrack();
        seenLow = 1'b0;
        runLen = 0;
        lastRun = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            trackSamples(k);
            if (integRst) begin
                if (seenLow) runLen++;
            end else begin
                if (runLen > 0) lastRun = runLen;
                runLen = 0;
                seenLow = 1'b1;
            end
        end
        checkOutput("cont_gap", lastRun, 3);
        checkOutput("cont_samples", sampleCount, 3);
        checkOutput("cont_no_overrun", overrun, 0);
        cont = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        tick();
        resReady = 1'b0;
        checkOutput("cont_stop_busy", busy, 0);
        checkOutput("cont2_stop_busy", busy2, 0);

        // Asynchronous reset in the middle of INTEG after one counted edge.
        applyStimulus(8'd2, 8'd5);
        tick();
        trigIn = 1'b1;
        tick();
        trigIn = 1'b0;
        tick();
        tick();
        checkOutput("mid_wrap_pre", wrapCnt, 1);
        checkOutput("mid_integ_rst_pre", integRst, 0);
        #3 rstn = 1'b0;
        #1;
        checkOutput("mid_rst_integ_rst", integRst, 1);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_res_valid", resValid, 0);
        checkOutput("mid_rst_wrap_cnt", wrapCnt, 0);
        #2 rstn = 1'b1;
        tick();

        // Zero lengths behave as one cycle.
        applyStimulus(8'd0, 8'd0);
        clearTrack();
        for (int k = 1; k <= 4; k++) begin
            tick();
            trackSamples(k);
        end
        checkOutput("zero_sample_at", sampleAt, 2);
        checkOutput("zero2_sample_at", sampleAt2, 1);
        checkOutput("zero_res_valid", resValid, 1);
        resReady = 1'b1;
        tick();
        resReady = 1'b0;
        checkOutput("zero_idle_busy", busy, 0);

        // Five edges: 8-bit count reaches 5, 2-bit count saturates at 3.
        applyStimulus(8'd1, 8'd12);
        clearTrack();
        trigPat = 16'b0000_0010_1010_1010;
        for (int k = 1; k <= 14; k++) begin
            trigIn = trigPat[k];
            tick();
            trackSamples(k);
        end
        trigIn = 1'b0;
        checkOutput("sat_wrap_cnt", wrapCnt, 5);
        checkOutput("sat2_wrap_cnt", wrapCnt2, 3);
        checkOutput("sat_sample_at", sampleAt, 13);
        checkOutput("sat2_sample_at", sampleAt2, 12);

        // dut2 has held its result since E13; with the timeout build it gives up at E17.
        tick();
        tick();
        checkOutput("tmo_valid_held", resValid2, 1);
        tick();
`ifdef INTEG_CTRL_TIMEOUT_EN
        checkOutput("tmo_valid_dropped", resValid2, 0);
        checkOutput("tmo_overrun", overrun2, 1);
`else
        checkOutput("tmo_valid_waits", resValid2, 1);
        checkOutput("tmo_no_overrun", overrun2, 0);
`endif
        checkOutput("tmo_dut_valid", resValid, 1);
        resReady = 1'b1;
        tick();
        resReady = 1'b0;
        tick();
        checkOutput("end_busy", busy, 0);
        checkOutput("end2_busy", busy2, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
